// File: rtl/dbg_ins_enc_pkg.sv
// dbg_ins_enc_pkg: op/state types and RV32I/Zicsr encoding constants for the debug instruction encoder.
// Op 5 (MRET) is legal only when DBG_INS_ENC_MRET_EN is defined.
package dbg_ins_enc_pkg;
    typedef enum logic [2:0] {
        OP_LI   = 3'd0,
        OP_CSRR = 3'd1,
        OP_CSRW = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_MRET = 3'd5
    } op_e;

    typedef enum logic [1:0] {IDLE, INS0, INS1, DRAIN} state_e;
    typedef enum logic [1:0] {FMT_U, FMT_I, FMT_S} fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;

    localparam logic [2:0] F3_ADDI  = 3'd0;
    localparam logic [2:0] F3_CSRRW = 3'd1;
    localparam logic [2:0] F3_CSRRS = 3'd2;
    localparam logic [2:0] F3_LW    = 3'd2;
    localparam logic [2:0] F3_SW    = 3'd2;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MRET = 32'h3020_0073;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef DBG_INS_ENC_MRET_EN
        return op <= 3'd5;
`else
        return op <= 3'd4;
`endif
    endfunction
endpackage

// File: rtl/rv32_ins_fmt.sv
// rv32_ins_fmt: packs U/I/S-type RV32 instruction words from their fields.
module rv32_ins_fmt
    import dbg_ins_enc_pkg::*;
(
    input  fmt_e        fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [19:0] imm_i,
    output logic [31:0] ins_o
);
    always_comb
        ins_o = fmt_i == FMT_U ? {imm_i, rd_i, opcode_i}
              : fmt_i == FMT_S ? {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i}
              : {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
endmodule

// File: rtl/dbg_ins_encoder.sv
// dbg_ins_encoder: encodes abstract debug commands into RV32I/Zicsr words and streams them, then drain NOPs.
// Define DBG_INS_ENC_MRET_EN to accept op 5 (MRET).
module dbg_ins_encoder
    import dbg_ins_enc_pkg::*;
#(
    parameter int DRAIN_NOPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rs2,
    input  logic [11:0] cmd_csr,
    input  logic [31:0] cmd_imm,
    input  logic        abort,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_out,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW = DRAIN_NOPS < 2 ? 1 : $clog2(DRAIN_NOPS + 1);

    state_e         state_q;
    op_e            op_q;
    logic [4:0]     rd_q, rs_q, rs2_q;
    logic [11:0]    csr_q;
    logic [31:0]    imm_q;
    logic           long_q, ins_valid_q, done_q, err_q;
    logic [31:0]    ins_out_q;
    logic [CW-1:0]  cnt_q;

    logic           idle, long_d;
    op_e            op_s;
    logic [4:0]     rd_s, rs_s, rs2_s, rd_f, rs1_f;
    logic [11:0]    csr_s;
    logic [31:0]    imm_s, fmt_ins, ins_d;
    logic [19:0]    hi_s, imm_f;
    fmt_e           fmt;
    logic [6:0]     opc;
    logic [2:0]     f3;

    assign idle = state_q == IDLE;

    // In IDLE the next word is slot 0 of the incoming command, otherwise slot 1 of the latched one
    always_comb begin
        op_s   = idle ? op_e'(cmd_op) : op_q;
        rd_s   = idle ? cmd_rd : rd_q;
        rs_s   = idle ? cmd_rs : rs_q;
        rs2_s  = idle ? cmd_rs2 : rs2_q;
        csr_s  = idle ? cmd_csr : csr_q;
        imm_s  = idle ? cmd_imm : imm_q;
        hi_s   = imm_s[31:12] + {19'd0, imm_s[11]};
        long_d = op_s == OP_LI && hi_s != 20'd0;
        fmt    = FMT_I;
        opc    = OPC_OP_IMM;
        f3     = F3_ADDI;
        rd_f   = rd_s;
        rs1_f  = 5'd0;
        imm_f  = {8'd0, imm_s[11:0]};
        case (op_s)
            OP_LI: begin
                fmt   = idle && long_d ? FMT_U : FMT_I;
                opc   = idle && long_d ? OPC_LUI : OPC_OP_IMM;
                imm_f = idle && long_d ? hi_s : {8'd0, imm_s[11:0]};
                rs1_f = idle ? 5'd0 : rd_s;
            end
            OP_CSRR: begin
                opc   = OPC_SYSTEM;
                f3    = F3_CSRRS;
                imm_f = {8'd0, csr_s};
            end
            OP_CSRW: begin
                opc   = OPC_SYSTEM;
                f3    = F3_CSRRW;
                rd_f  = 5'd0;
                rs1_f = rs_s;
                imm_f = {8'd0, csr_s};
            end
            OP_LW: begin
                opc   = OPC_LOAD;
                f3    = F3_LW;
                rs1_f = rs_s;
            end
            OP_SW: begin
                fmt   = FMT_S;
                opc   = OPC_STORE;
                f3    = F3_SW;
                rs1_f = rs_s;
            end
            default: ;
        endcase
    end

    rv32_ins_fmt u_fmt (
        .fmt_i   (fmt),
        .opcode_i(opc),
        .rd_i    (rd_f),
        .funct3_i(f3),
        .rs1_i   (rs1_f),
        .rs2_i   (rs2_s),
        .imm_i   (imm_f),
        .ins_o   (fmt_ins)
    );

    assign ins_d = op_s == OP_MRET ? MRET : fmt_ins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LI;
            rd_q        <= '0;
            rs_q        <= '0;
            rs2_q       <= '0;
            csr_q       <= '0;
            imm_q       <= '0;
            long_q      <= 1'b0;
            ins_valid_q <= 1'b0;
            ins_out_q   <= NOP;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                ins_valid_q <= 1'b0;
                ins_out_q   <= NOP;
                cnt_q       <= '0;
            end else if (idle) begin
                if (cmd_valid && op_legal(cmd_op)) begin
                    state_q     <= INS0;
                    op_q        <= op_s;
                    rd_q        <= cmd_rd;
                    rs_q        <= cmd_rs;
                    rs2_q       <= cmd_rs2;
                    csr_q       <= cmd_csr;
                    imm_q       <= cmd_imm;
                    long_q      <= long_d;
                    ins_valid_q <= 1'b1;
                    ins_out_q   <= ins_d;
                end else if (cmd_valid) begin
                    err_q <= 1'b1;
                end
            end else if (ins_ready) begin
                if (state_q == INS0 && long_q) begin
                    state_q   <= INS1;
                    ins_out_q <= ins_d;
                end else if (state_q == DRAIN ? cnt_q == CW'(1) : DRAIN_NOPS == 0) begin
                    state_q     <= IDLE;
                    ins_valid_q <= 1'b0;
                    ins_out_q   <= NOP;
                    done_q      <= 1'b1;
                    cnt_q       <= '0;
                end else begin
                    state_q   <= DRAIN;
                    ins_out_q <= NOP;
                    cnt_q     <= state_q == DRAIN ? cnt_q - 1'b1 : CW'(DRAIN_NOPS);
                end
            end
        end
    end

    assign cmd_ready = idle;
    assign busy      = !idle;
    assign ins_valid = ins_valid_q;
    assign ins_out   = ins_out_q;
    assign done      = done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_dbg_ins_encoder.sv
// tb_dbg_ins_encoder: vector table, hand-written corner sequences and randomized commands
// checked against an instruction-format reference model.
module tb_dbg_ins_encoder;
    localparam int DRAIN_NOPS = 4;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, abort = 1'b0, ins_ready = 1'b1;
    logic        cmd_ready, ins_valid, busy, done, err;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_rd = '0, cmd_rs = '0, cmd_rs2 = '0;
    logic [11:0] cmd_csr = '0;
    logic [31:0] cmd_imm = '0, ins_out;

    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dbg_ins_encoder #(.DRAIN_NOPS(DRAIN_NOPS)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rs2(cmd_rs2),
        .cmd_csr(cmd_csr), .cmd_imm(cmd_imm), .abort(abort), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_out(ins_out), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] enc_i(bit [31:0] imm, bit [31:0] rs1, bit [31:0] f3, bit [31:0] rd, bit [31:0] opc);
        return ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
    endfunction

    function automatic bit [31:0] enc_s(bit [31:0] imm, bit [31:0] rs1, bit [31:0] rs2, bit [31:0] f3, bit [31:0] opc);
        return (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | ((imm & 32'h1f) << 7) | opc;
    endfunction

    // Fills exp_q with the command's instruction words; returns whether the op is legal
    function automatic bit model(bit [2:0] op, bit [4:0] rd, bit [4:0] rs, bit [4:0] rs2, bit [11:0] csr, bit [31:0] imm);
        bit [31:0] hi;
        exp_q.delete();
        hi = (imm + 32'h800) >> 12;
        case (op)
            3'd0: begin
                if (hi != 0) begin
                    exp_q.push_back((hi << 12) | (32'(rd) << 7) | 32'h37);
                    exp_q.push_back(enc_i(imm, 32'(rd), 0, 32'(rd), 32'h13));
                end else begin
                    exp_q.push_back(enc_i(imm, 0, 0, 32'(rd), 32'h13));
                end
            end
            3'd1: exp_q.push_back(enc_i(32'(csr), 0, 2, 32'(rd), 32'h73));
            3'd2: exp_q.push_back(enc_i(32'(csr), 32'(rs), 1, 0, 32'h73));
            3'd3: exp_q.push_back(enc_i(imm, 32'(rs), 2, 32'(rd), 32'h03));
            3'd4: exp_q.push_back(enc_s(imm, 32'(rs), 32'(rs2), 2, 32'h23));
`ifdef DBG_INS_ENC_MRET_EN
            3'd5: exp_q.push_back(32'h3020_0073);
`endif
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // mode 0: ins_ready high; 1: random ins_ready; 2: ins_ready low for the first 3 cycles
    task automatic run_cmd(string name, bit [2:0] op, bit [4:0] rd, bit [4:0] rs, bit [4:0] rs2,
                           bit [11:0] csr, bit [31:0] imm, bit legal, int mode);
        int k, idx, n_ins;
        logic [31:0] held;
        bit stalled;
        n_ins = exp_q.size();
        if (legal) for (int i = 0; i < DRAIN_NOPS; i++) exp_q.push_back(NOP_W);
        @(negedge clk);
        chk({name, " done_one_cycle"}, 32'(done), 0);
        chk({name, " cmd_ready"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rs2 = rs2; cmd_csr = csr; cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!legal) begin
            chk({name, " err"}, 32'(err), 1);
            chk({name, " err_no_valid"}, 32'(ins_valid), 0);
            chk({name, " err_busy"}, 32'(busy), 0);
            @(negedge clk);
            chk({name, " err_pulse"}, 32'(err), 0);
            chk({name, " err_no_done"}, 32'(done), 0);
            chk({name, " err_no_valid2"}, 32'(ins_valid), 0);
            return;
        end
        k = 1; idx = 0; stalled = 0; held = '0;
        while (k < 100) begin
            if (stalled) begin
                chk({name, " hold_valid"}, 32'(ins_valid), 1);
                chk({name, " hold_ins"}, ins_out, held);
            end
            if (done) break;
            ins_ready = mode == 1 ? ($urandom_range(0, 2) != 0) : (mode == 2 && k <= 3) ? 1'b0 : 1'b1;
            if (ins_valid && ins_ready) begin
                chk({name, " ins"}, ins_out, idx < exp_q.size() ? exp_q[idx] : 32'hxxxx_xxxx);
                idx++;
                stalled = 0;
            end else if (ins_valid) begin
                stalled = 1;
                held = ins_out;
            end
            @(negedge clk);
            k++;
        end
        ins_ready = 1'b1;
        chk({name, " done"}, 32'(done), 1);
        chk({name, " count"}, 32'(idx), 32'(exp_q.size()));
        chk({name, " idle_at_done"}, 32'(ins_valid), 0);
        if (mode == 0) chk({name, " latency"}, 32'(k), 32'(n_ins + DRAIN_NOPS + 1));
    endtask

    typedef struct {
        string      name;
        bit [2:0]   op;
        bit [4:0]   rd, rs, rs2;
        bit [11:0]  csr;
        bit [31:0]  imm;
        int         n;
        bit [31:0]  e0, e1;
        int         mode;
    } vec_t;

    vec_t tbl[7];

    initial begin
        bit [2:0] op;
        bit [4:0] rd, rs, rs2;
        bit [11:0] csr;
        bit [31:0] imm;
        bit legal;
        tbl[0] = '{"li_split", 3'd0, 5'd5, 5'd0, 5'd0, 12'h0, 32'h1234_5FFF, 2, 32'h1234_62B7, 32'hFFF2_8293, 0};
        tbl[1] = '{"li_short", 3'd0, 5'd5, 5'd0, 5'd0, 12'h0, 32'h0000_0123, 1, 32'h1230_0293, 32'h0, 0};
        tbl[2] = '{"csrr", 3'd1, 5'd10, 5'd0, 5'd0, 12'h300, 32'h0, 1, 32'h3000_2573, 32'h0, 0};
        tbl[3] = '{"csrw", 3'd2, 5'd0, 5'd6, 5'd0, 12'h305, 32'h0, 1, 32'h3053_1073, 32'h0, 0};
        tbl[4] = '{"sw_stall", 3'd4, 5'd0, 5'd2, 5'd7, 12'h0, 32'h0000_0008, 1, 32'h0071_2423, 32'h0, 2};
        tbl[5] = '{"li_x0_800", 3'd0, 5'd0, 5'd0, 5'd0, 12'h0, 32'h0000_0800, 2, 32'h0000_1037, 32'h8000_0013, 0};
        tbl[6] = '{"lw_neg", 3'd3, 5'd3, 5'd1, 5'd0, 12'h0, 32'hFFFF_FFFC, 1, 32'hFFC0_A183, 32'h0, 0};

        @(negedge clk);
        chk("rst ins_valid", 32'(ins_valid), 0);
        chk("rst ins_out", ins_out, NOP_W);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst err", 32'(err), 0);
        chk("rst cmd_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            exp_q.delete();
            exp_q.push_back(tbl[i].e0);
            if (tbl[i].n == 2) exp_q.push_back(tbl[i].e1);
            run_cmd(tbl[i].name, tbl[i].op, tbl[i].rd, tbl[i].rs, tbl[i].rs2, tbl[i].csr, tbl[i].imm, 1'b1, tbl[i].mode);
        end

        // Abort during DRAIN: back to IDLE next cycle, done never pulses
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 5'd10; cmd_csr = 12'h300;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("abort_drain ins", ins_out, 32'h3000_2573);
        @(negedge clk);
        chk("abort_drain in_drain", ins_out, NOP_W);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_drain busy", 32'(busy), 0);
        chk("abort_drain valid", 32'(ins_valid), 0);
        chk("abort_drain done", 32'(done), 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_drain quiet", {30'd0, done, ins_valid}, 0);
        end

        // Abort wins over a same-cycle handshake on the first word of a split LI
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 5'd5; cmd_imm = 32'h1234_5FFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ins0 busy", 32'(busy), 0);
        chk("abort_ins0 valid", 32'(ins_valid), 0);
        @(negedge clk);
        chk("abort_ins0 no_resume", {30'd0, done, ins_valid}, 0);

        legal = model(3'd6, 5'd1, 5'd2, 5'd3, 12'h0, 32'h0);
        run_cmd("illegal6", 3'd6, 5'd1, 5'd2, 5'd3, 12'h0, 32'h0, legal, 0);
        legal = model(3'd5, 5'd0, 5'd0, 5'd0, 12'h0, 32'h0);
        run_cmd("mret", 3'd5, 5'd0, 5'd0, 5'd0, 12'h0, 32'h0, legal, 0);

        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom);
            rs  = 5'($urandom);
            rs2 = 5'($urandom);
            csr = 12'($urandom);
            case ($urandom_range(0, 3))
                0: imm = 32'($urandom_range(0, 32'h7ff));
                1: imm = 32'hFFFF_F800 | 32'($urandom_range(0, 32'h7ff));
                default: imm = $urandom;
            endcase
            legal = model(op, rd, rs, rs2, csr, imm);
            run_cmd("rnd", op, rd, rs, rs2, csr, imm, legal, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dbg_ins_encoder.md
# dbg_ins_encoder

Instruction encoder/injector: the encode-side counterpart of the decode-stage control logic. It accepts abstract debug commands (load immediate, CSR read/write, word load/store), encodes each as one or two legal RV32I/Zicsr instructions, and streams them to the fetch stage over a valid/ready handshake. After each command it appends a configurable run of NOPs so the pipeline drains before completion is reported. It sits between the debug module and the IF stage's instruction mux.

## Interface
- `DRAIN_NOPS`, default 4: NOPs appended after each command's final instruction (0 allowed).
- `clk` input 1: core clock.
- `rst_n` input 1: reset, asynchronous assert and active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: high only in IDLE; a command is accepted on `cmd_valid && cmd_ready`.
- `cmd_op` input 3: 0 LI, 1 CSRR, 2 CSRW, 3 LW, 4 SW, 5 MRET (macro-gated), 6–7 illegal.
- `cmd_rd` input 5: destination GPR.
- `cmd_rs` input 5: source GPR (rs1 for CSRW/LW/SW base).
- `cmd_rs2` input 5: store data GPR (SW only).
- `cmd_csr` input 12: CSR address.
- `cmd_imm` input 32: LI value; LW/SW offset uses `[11:0]`.
- `abort` input 1: synchronous cancel, e.g. on pipeline flush.
- `ins_valid` output 1: `ins_out` is valid.
- `ins_ready` input 1: IF stage takes the instruction.
- `ins_out` output 32: encoded instruction.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when the command completes.
- `err` output 1: one-cycle pulse on an illegal op.

## Operation
- FSM states: IDLE, INS0, INS1, DRAIN.
- **IDLE**:
  - A legal command latches all cmd fields, then moves to INS0; INS1 is skipped for single-instruction ops.
  - An illegal op pulses `err` the next cycle and stays in IDLE. No instruction is emitted and `done` does not pulse.
- **LI**:
  - lo = imm[11:0] sign-extended; hi = (imm + 0x800) >> 12, truncated to 20 bits (mod 2^32).
  - hi != 0: emit `LUI rd,hi` then `ADDI rd,rd,lo`.
  - hi == 0: emit only `ADDI rd,x0,lo`.
- **CSRR**: `CSRRS rd,csr,x0`.
- **CSRW**: `CSRRW x0,csr,rs`.
- **LW**: `LW rd,imm(rs)`.
- **SW**: `SW rs2,imm(rs)`, with the S-type immediate split.
- **MRET**: 0x30200073.
- After the last instruction's handshake:
  - Go to DRAIN, loading the counter with `DRAIN_NOPS`. DRAIN emits 0x00000013 until the counter reaches 0.
  - If `DRAIN_NOPS` == 0, go straight to IDLE.
- Entering IDLE from DRAIN/INS pulses `done`. A new command may be accepted in that same cycle.
- **abort**: in any state, next cycle is IDLE. `ins_valid` drops, `done` does not pulse, and no partial sequence is resumed.
- `cmd_rd` == 0 is legal (writes discarded by the core); encode it faithfully.

## Timing
- Reset values: state IDLE, `ins_valid` 0, `ins_out` 0x00000013, `busy` 0, `done` 0, `err` 0, drain counter 0. `cmd_ready` is 1 (combinational from IDLE).
- Command accepted at edge N: `ins_valid` is high from cycle N+1.
- `ins_out` and `ins_valid` are registered. Both hold stable while `ins_valid && !ins_ready`.
- One instruction per cycle at most, with back-to-back handshakes under continuous `ins_ready`.
- Minimum command-to-`done` latency with `ins_ready` held high: (instruction count + `DRAIN_NOPS`) + 1 cycles.
- `abort` has priority over a same-cycle handshake. That instruction counts as not delivered.

## Configuration
- `DBG_INS_ENC_MRET_EN` defined: op 5 emits MRET, then drains.
- Not defined: op 5 is illegal and pulses `err`.

## Structure
- Package `dbg_ins_enc_pkg` holds:
  - the op enum;
  - opcode constants 0x37 LUI, 0x13 OP-IMM, 0x73 SYSTEM, 0x03 LOAD, 0x23 STORE;
  - funct3 values;
  - `NOP` = 0x00000013 and `MRET` = 0x30200073.
- One combinational sub-module, `rv32_ins_fmt`, packs U/I/S-type words from (opcode, rd, funct3, rs1, rs2, imm).

## Test plan
- **LI split**: LI x5, 0x12345FFF, `DRAIN_NOPS`=4, `ins_ready`=1 -> 0x123462B7, 0xFFF28293, four 0x00000013; `done` pulses 7 cycles after acceptance.
- **LI short form**: LI x5, 0x00000123 -> single 0x12300293.
- **CSR ops**: CSRR x10, 0x300 -> 0x30002573; CSRW 0x305, x6 -> 0x30531073.
- **Store backpressure**: SW x7, 8(x2) with `ins_ready` low 3 cycles -> 0x00712423 held stable throughout, emitted exactly once.
- **Abort and illegal op**: `abort` during DRAIN -> IDLE next cycle, no `done`. Op 6 -> `err` pulse, no `ins_valid`.
- **MRET gating**: op 5 -> 0x30200073 with the macro defined; `err` without it.
